// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, dimensions and state encoding for the matrix load sequencer
package mult_pkg;

    localparam int W_IN   = 8;
    localparam int W_OUT  = 16;
    localparam int ROWS_A = 2;
    localparam int COLS_B = 3;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_SETTLE,
        ST_RD_ADDR,
        ST_RD_CAPT,
        ST_RD_PRES
    } state_t;

endpackage

// File: rtl/matrix_load_seq.sv
// rtl/matrix_load_seq.sv - loads A/B operand vectors into an outer-product multiplier and streams out its results
module matrix_load_seq
    import mult_pkg::*;
#(
    parameter int W_IN       = mult_pkg::W_IN,
    parameter int W_OUT      = mult_pkg::W_OUT,
    parameter int ROWS_A     = mult_pkg::ROWS_A,
    parameter int COLS_B     = mult_pkg::COLS_B,
    parameter int SETTLE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [W_IN-1:0]  s_data,
    output logic                    data_in,
    output logic                    mem_sel,
    output logic [ROW_W-1:0]        row_in,
    output logic [COL_W-1:0]        col_in,
    output logic signed [W_IN-1:0]  data,
    output logic [ROW_W-1:0]        row_out,
    output logic [COL_W-1:0]        col_out,
    input  logic signed [W_OUT-1:0] mult_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [W_OUT-1:0] m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic                    done
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    s_ready_q, s_ready_d;
    logic                    data_in_q, data_in_d;
    logic                    mem_sel_q, mem_sel_d;
    logic [ROW_W-1:0]        row_in_q, row_in_d;
    logic [COL_W-1:0]        col_in_q, col_in_d;
    logic signed [W_IN-1:0]  data_q, data_d;
    logic [ROW_W-1:0]        row_out_q, row_out_d;
    logic [COL_W-1:0]        col_out_q, col_out_d;
    logic                    m_valid_q, m_valid_d;
    logic signed [W_OUT-1:0] m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    last_idx;

    assign last_idx = (row_out_q == ROW_W'(ROWS_A - 1)) && (col_out_q == COL_W'(COLS_B - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            data_in_q <= 1'b0;
            mem_sel_q <= 1'b0;
            row_in_q  <= '0;
            col_in_q  <= '0;
            data_q    <= '0;
            row_out_q <= '0;
            col_out_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            data_in_q <= data_in_d;
            mem_sel_q <= mem_sel_d;
            row_in_q  <= row_in_d;
            col_in_q  <= col_in_d;
            data_q    <= data_d;
            row_out_q <= row_out_d;
            col_out_q <= col_out_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_in_d = 1'b0;
        mem_sel_d = mem_sel_q;
        row_in_d  = row_in_q;
        col_in_d  = col_in_q;
        data_d    = data_q;
        row_out_d = row_out_q;
        col_out_d = col_out_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                    cnt_d   = '0;
                end
            end
            ST_LOAD_A: begin
                if (s_valid) begin
                    data_in_d = 1'b1;
                    mem_sel_d = 1'b0;
                    row_in_d  = cnt_q[ROW_W-1:0];
                    data_d    = s_data;
                    if (cnt_q == CNT_W'(ROWS_A - 1)) begin
                        state_d = ST_LOAD_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                if (s_valid) begin
                    data_in_d = 1'b1;
                    mem_sel_d = 1'b1;
                    col_in_d  = cnt_q[COL_W-1:0];
                    data_d    = s_data;
                    if (cnt_q == CNT_W'(COLS_B - 1)) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // The multiplier writes every cycle; re-writing the last B element keeps its contents intact.
            ST_SETTLE: begin
                data_in_d = 1'b1;
                mem_sel_d = 1'b1;
                col_in_d  = COL_W'(COLS_B - 1);
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d   = ST_RD_ADDR;
                    cnt_d     = '0;
                    row_out_d = '0;
                    col_out_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_ADDR: begin
                data_in_d = 1'b1;
                state_d   = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                data_in_d = 1'b1;
                m_data_d  = mult_out;
                m_last_d  = last_idx;
                state_d   = ST_RD_PRES;
            end
            ST_RD_PRES: begin
                data_in_d = 1'b1;
                if (m_ready) begin
                    m_last_d = 1'b0;
                    if (last_idx) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        data_in_d = 1'b0;
                    end else begin
                        state_d = ST_RD_ADDR;
                        if (col_out_q == COL_W'(COLS_B - 1)) begin
                            col_out_d = '0;
                            row_out_d = row_out_q + ROW_W'(1);
                        end else begin
                            col_out_d = col_out_q + COL_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        m_valid_d = (state_d == ST_RD_PRES);
        busy_d    = (state_d != ST_IDLE);
    end

    assign s_ready = s_ready_q;
    assign data_in = data_in_q;
    assign mem_sel = mem_sel_q;
    assign row_in  = row_in_q;
    assign col_in  = col_in_q;
    assign data    = data_q;
    assign row_out = row_out_q;
    assign col_out = col_out_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/matrix_load_seq.md
MATRIX_LOAD_SEQ -- requirements
Module: matrix_load_seq

Interface
REQ-001 SHALL have parameter W_IN, default 8, meaning operand width (signed).
REQ-002 SHALL have parameter W_OUT, default 16, meaning product width (signed).
REQ-003 SHALL have parameter ROWS_A, default 2, meaning A entries (column vector).
REQ-004 SHALL have parameter COLS_B, default 3, meaning B entries (row vector).
REQ-005 SHALL have parameter SETTLE_CYC, default 2, meaning cycles between the last B write and the first result read.
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin one transaction; sampled only in IDLE.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accepted when s_valid && s_ready.
- s_data  in  W_IN  signed operand.
- data_in  out  1  multiplier enable.
- mem_sel  out  1  0 = write A, 1 = write B.
- row_in  out  2  A write index.
- col_in  out  3  B write index.
- data  out  W_IN  multiplier write data.
- row_out  out  2  result read row.
- col_out  out  3  result read column.
- mult_out  in  W_OUT  multiplier result, registered, 1-cycle read latency.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  W_OUT  signed product.
- m_last  out  1  high with the final (row 1, col 2) result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the final m handshake.

Function
REQ-007 SHALL be a registered FSM with states IDLE, LOAD_A, LOAD_B, SETTLE, RD_ADDR, RD_CAPT, RD_PRES, and all outputs registered.
REQ-008 IDLE: start=1 -> LOAD_A; start asserted in any other state SHALL be ignored.
REQ-009 LOAD_A/LOAD_B: s_ready=1; beats accepted in order A[0..ROWS_A-1], then B[0..COLS_B-1]; the ROWS_A-th beat -> LOAD_B; the COLS_B-th beat -> SETTLE.
REQ-010 For each accepted beat, the following cycle SHALL carry data_in=1, data=s_data, and mem_sel/row_in/col_in for that element; in load cycles with no accepted beat, data_in=0; s_valid gaps of any length are legal.
REQ-011 From SETTLE through RD_PRES, data_in SHALL be held at 1, with mem_sel=1, col_in=COLS_B-1, and data=last B beat, so that the multiplier's continuous writes are value-preserving.
REQ-012 SETTLE SHALL last exactly SETTLE_CYC cycles, then -> RD_ADDR with index 0.
REQ-013 The read index SHALL run in row-major order 0..ROWS_A*COLS_B-1, with row_out=idx/COLS_B and col_out=idx%COLS_B, driven in RD_ADDR and held through RD_PRES.
REQ-014 RD_ADDR lasts 1 cycle -> RD_CAPT; RD_CAPT lasts 1 cycle, captures mult_out into m_data, and -> RD_PRES.
REQ-015 RD_PRES: m_valid=1; m_data and m_last SHALL be held stable until m_ready=1; on the handshake, the last index -> IDLE with done=1 for 1 cycle; otherwise idx+1 -> RD_ADDR.
REQ-016 m_valid SHALL be 0 outside RD_PRES; s_ready SHALL be 0 outside LOAD_A/LOAD_B.
REQ-017 No arithmetic in this block; m_data SHALL be passed through sign-exact, W_OUT bits.
REQ-018 A new start after done SHALL run a full fresh transaction; no state is carried between transactions except the held data/address registers.

Reset
REQ-019 reset SHALL force IDLE asynchronously, at any state including mid-load or mid-read.
REQ-020 All outputs and counters SHALL reset to 0: s_ready, data_in, mem_sel, row_in, col_in, data, row_out, col_out, m_valid, m_data, m_last, busy, done.
REQ-021 The same reset net SHALL drive the multiplier's reset.
REQ-022 After reset deasserts, operation SHALL resume only on a new start; partial operands are discarded.

Structure
REQ-023 Shared package mult_pkg SHALL hold W_IN, W_OUT, ROWS_A, COLS_B, the state encoding, and the index widths.
REQ-024 The block SHALL be a single module with no sub-modules; it instantiates nothing and connects port-to-port to the multiplier.

Verification
REQ-025 Bench SHALL cover: start; A={3,-2}, B={4,5,-1}; m_ready=1 -> m_data 12,15,-3,-8,-10,2, m_last on the 6th beat, done 1 cycle later.
REQ-026 Bench SHALL cover: A={-128,127}, B={-128,127,1} -> 16384,-16256,-128,-16256,16129,127.
REQ-027 Bench SHALL cover: m_ready=0 for 5 cycles while the 3rd result is presented -> m_data=-3 held stable, no index skip, and the remaining results are correct.
REQ-028 Bench SHALL cover: s_valid toggling 1,0,0,1 between beats -> the same results as REQ-025 and data_in=0 in gap cycles.
REQ-029 Bench SHALL cover: reset pulsed during RD_PRES of result 2 -> all outputs 0 immediately and busy=0; a new transaction with REQ-025 operands -> correct 6 results.
REQ-030 Bench SHALL cover: start pulsed during LOAD_B and during RD_ADDR -> ignored, with sequence and results unchanged.
